// File: rtl/cdc_pulse_rx_multi.sv
// Multi-channel toggle-event receiver: synchronises per-channel toggle lines into d_clk,
// queues events in saturating counters and drains them through a round-robin valid/ready port.
module cdc_pulse_rx_multi #(
  parameter int CH    = 4,
  parameter int SYNC  = 2,
  parameter int CNT_W = 3,
  parameter int IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             d_clk,
  input  logic             d_rstn,
  input  logic [CH-1:0]    a_tgl,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [IDX_W-1:0] o_ch,
  output logic [CH-1:0]    pend,
  output logic [CH-1:0]    ovf,
  input  logic [CH-1:0]    ovf_clr,
  output logic             busy
);

  localparam int WARM   = SYNC + 1;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]    sync_q [SYNC];
  logic [CH-1:0]    prev_q;
  logic [CH-1:0]    evt_raw;
  logic [CH-1:0]    evt_q;
  logic [WARM_W-1:0] warm_q;
  logic             warm_done;

  logic [CNT_W-1:0] cnt_q [CH];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] ptr_nxt;
  logic             any_pend;
  logic             load;
  logic             grant;
  logic [CH-1:0]    dec;
  logic [CH-1:0]    ovf_set;

  // Edges are ignored until prev_q has absorbed the post-reset level of the sync chain.
  assign warm_done = (warm_q == WARM_W'(WARM));
  assign evt_raw   = (sync_q[SYNC-1] ^ prev_q) & {CH{warm_done}};

  always_ff @(posedge d_clk) begin
    if (!d_rstn) begin
      for (int unsigned k = 0; k < SYNC; k++) sync_q[k] <= '0;
      prev_q <= '0;
      evt_q  <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= a_tgl;
      for (int unsigned k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC-1];
      evt_q  <= evt_raw;
      if (!warm_done) warm_q <= warm_q + 1'b1;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < CH; i++) pend[i] = (cnt_q[i] != '0);
  end

  assign any_pend = |pend;
  assign load     = !o_vld || o_rdy;
  assign grant    = load && any_pend;
  assign busy     = any_pend || o_vld;

  // Round-robin: first pending channel at or above ptr_q, wrapping to zero.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= CH) idx = idx - CH;
      if (!found && pend[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign ptr_nxt = (sel == IDX_W'(CH - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    dec     = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      dec[i]     = grant && (sel == IDX_W'(i));
      ovf_set[i] = evt_q[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge d_clk) begin
    if (!d_rstn) begin
      o_vld <= 1'b0;
      o_ch  <= '0;
      ptr_q <= '0;
      ovf   <= '0;
      for (int unsigned i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      if (load) begin
        o_vld <= any_pend;
        if (any_pend) begin
          o_ch  <= sel;
          ptr_q <= ptr_nxt;
        end
      end
      // A simultaneous arrival and grant cancel out, so a full counter never overflows then.
      for (int unsigned i = 0; i < CH; i++) begin
        if (evt_q[i] && !dec[i]) begin
          if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !evt_q[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        ovf[i] <= ovf_set[i] | (ovf[i] & ~ovf_clr[i]);
      end
    end
  end

endmodule
